// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts a reload value down to zero and pulses
// done on terminal count, with one-shot / auto-reload modes, pause and abort.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    // Priority: load, then stop, then start / run activity.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            reload_d = load_val;
            count_d  = load_val;
            state_d  = IDLE;
        end else if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_d = reload_q;
                        if (reload_q != ZERO) begin
                            state_d = RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else if (count_q == ONE) begin
                            count_d = ZERO;
                            done_d  = 1'b1;
                            if (!auto_reload) begin
                                state_d = IDLE;
                            end
                        end else begin
                            // Count of zero in RUN only follows an auto-reload terminal count.
                            count_d = reload_q;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Bench for down_counter_timer: directed scenarios plus randomized runs checked
// against a position-based model of the count sequence.
module tb_down_counter_timer;

    localparam int W  = 4;
    localparam int EW = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         stop;
    logic         pause;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    down_counter_timer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
        .stop(stop), .pause(pause), .auto_reload(auto_reload),
        .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wire [EW-1:0] obs = {count, busy, done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        pause = 1'b0; auto_reload = 1'b0;
    endtask

    // Model: p counts the edges that moved the sequence forward since start.
    function automatic logic [EW-1:0] model_out(int n, bit ar, int p, bit adv);
        logic [W-1:0] c;
        int r;
        if (n == 0) begin
            c = '0;
            return {c, 1'b0, (p == 0)};
        end
        if (ar) begin
            r = p % (n + 1);
            c = W'(n - r);
            return {c, 1'b1, (r == n) && adv};
        end
        c = (p >= n) ? '0 : W'(n - p);
        return {c, (p < n), (p == n) && adv};
    endfunction

    task automatic run_seq(input string name, input int n, input bit ar, input int cycles,
                           input int pause_pct, input int pause_lo, input int pause_hi,
                           input int start_pct);
        int p;
        bit busy_before, pz, sz, adv;
        logic [EW-1:0] e, last;
        logic [W-1:0] nv;
        nv = W'(n);
        load = 1'b1; load_val = nv; auto_reload = ar;
        step();
        load = 1'b0;
        n_checks++;
        if (obs !== {nv, 2'b00}) begin
            n_errors++;
            $display("FAIL %s load: got=%h exp=%h", name, obs, {nv, 2'b00});
        end
        start = 1'b1;
        p = 0;
        exp_q.push_back(model_out(n, ar, 0, 1'b1));
        step();
        start = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_errors++;
            $display("FAIL %s start edge: got=%h exp=%h", name, obs, e);
        end
        last = e;
        for (int j = 1; j <= cycles; j++) begin
            busy_before = (n != 0) && (ar || p < n);
            pz = ((j >= pause_lo) && (j <= pause_hi)) || ($urandom_range(0, 99) < pause_pct);
            sz = busy_before && ($urandom_range(0, 99) < start_pct);
            adv = !(busy_before && pz);
            if (adv) p++;
            exp_q.push_back(model_out(n, ar, p, adv));
            pause = pz;
            start = sz;
            step();
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e) begin
                n_errors++;
                $display("FAIL %s edge k+%0d: got count=%0d busy=%b done=%b exp count=%0d busy=%b done=%b",
                         name, j, count, busy, done, e[EW-1:2], e[1], e[0]);
            end
            last = e;
        end
        pause = 1'b0; start = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0; auto_reload = 1'b0;
        n_checks++;
        if (obs !== {last[EW-1:2], 2'b00}) begin
            n_errors++;
            $display("FAIL %s stop after run: got=%h exp=%h", name, obs, {last[EW-1:2], 2'b00});
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #12;
        n_checks++;
        if (obs !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_initial: got=%h exp=0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        n_checks++;
        if (obs !== {4'd5, 2'b10}) begin
            n_errors++;
            $display("FAIL reset_prerun: got=%h exp=%h", obs, {4'd5, 2'b10});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (obs !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_async: got=%h exp=0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (obs !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_hold: got=%h exp=0", obs);
        end
    endtask

    task automatic test_one_shot();
        run_seq("one_shot_4", 4, 1'b0, 6, 0, 0, -1, 0);
        run_seq("one_shot_7", 7, 1'b0, 9, 0, 0, -1, 0);
    endtask

    task automatic test_auto_reload();
        run_seq("auto_3", 3, 1'b1, 11, 0, 0, -1, 0);
        run_seq("auto_1", 1, 1'b1, 8, 0, 0, -1, 0);
    endtask

    task automatic test_pause();
        run_seq("pause_6", 6, 1'b0, 11, 0, 3, 5, 0);
        run_seq("pause_reload", 2, 1'b1, 10, 0, 2, 3, 0);
    endtask

    task automatic test_abort();
        load = 1'b1; load_val = 4'd9;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        n_checks++;
        if (obs !== {4'd7, 2'b10}) begin
            n_errors++;
            $display("FAIL abort_run7: got=%h exp=%h", obs, {4'd7, 2'b10});
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        repeat (2) step();
        n_checks++;
        if (obs !== {4'd7, 2'b00}) begin
            n_errors++;
            $display("FAIL abort_stop_hold: got=%h exp=%h", obs, {4'd7, 2'b00});
        end
        load = 1'b1; load_val = 4'd2; stop = 1'b1;
        step();
        load = 1'b0; stop = 1'b0;
        n_checks++;
        if (obs !== {4'd2, 2'b00}) begin
            n_errors++;
            $display("FAIL abort_load_stop: got=%h exp=%h", obs, {4'd2, 2'b00});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_checks++;
        if (obs !== {4'd1, 2'b10}) begin
            n_errors++;
            $display("FAIL abort_restart_1: got=%h exp=%h", obs, {4'd1, 2'b10});
        end
        step();
        n_checks++;
        if (obs !== {4'd0, 2'b01}) begin
            n_errors++;
            $display("FAIL abort_restart_done: got=%h exp=%h", obs, {4'd0, 2'b01});
        end
        // A load landing on the terminal-count edge must suppress done.
        load = 1'b1; load_val = 4'd3;
        step();
        load = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        load = 1'b1; load_val = 4'd5;
        step();
        load = 1'b0;
        n_checks++;
        if (obs !== {4'd5, 2'b00}) begin
            n_errors++;
            $display("FAIL abort_load_at_tc: got=%h exp=%h", obs, {4'd5, 2'b00});
        end
    endtask

    task automatic test_boundaries();
        run_seq("zero_oneshot", 0, 1'b0, 3, 0, 0, -1, 0);
        run_seq("zero_auto", 0, 1'b1, 3, 0, 0, -1, 0);
        run_seq("max_15", 15, 1'b0, 18, 0, 0, -1, 0);
        run_seq("start_midrun", 5, 1'b0, 8, 0, 0, -1, 100);
        run_seq("start_midrun_auto", 3, 1'b1, 9, 0, 0, -1, 100);
    endtask

    task automatic test_random();
        int n, cyc;
        bit ar;
        for (int i = 0; i < 10; i++) begin
            n   = $urandom_range(0, 15);
            ar  = 1'($urandom_range(0, 1));
            cyc = 2 * (n + 1) + $urandom_range(0, 8);
            run_seq($sformatf("random_%0d", i), n, ar, cyc, 25, 0, -1, 30);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_abort();
        test_boundaries();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
